// File: rtl/mac_source_ctrl.sv
// mac_source_ctrl
// ---------------
// Responder end of the streamer start handshake used by the MAC control FSM.
// One instance feeds one operand stream (a, b or c). After an accepted
// start request it reads trans_size words from TCDM, starting at base_addr
// with a DATA_W/8 byte stride. The returned words go into a small FIFO that
// is presented to the MAC engine as a valid/ready stream. done_o pulses once
// the last word has been consumed downstream.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear (abandons the current transfer)
//   req_start_i          start request pulse, honoured only while ready_start_o
//   base_addr_i          byte address of the first word
//   trans_size_i         number of words to transfer
//   ready_start_o        block is idle and has no TCDM reads outstanding
//   done_o               one-cycle pulse after the last stream handshake
//   tcdm_*               TCDM read master (req/gnt, in-order r_valid responses)
//   stream_data_o        FIFO head
//   stream_valid_o       FIFO not empty
//   stream_ready_i       downstream accepts the head word

module mac_source_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [LEN_W-1:0]      trans_size_i,
    output logic                  ready_start_o,
    output logic                  done_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_W-1:0]     tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [DATA_W/8-1:0]   tcdm_be_o,
    input  logic [DATA_W-1:0]     tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i,
    output logic [DATA_W-1:0]     stream_data_o,
    output logic                  stream_valid_o,
    input  logic                  stream_ready_i
);

    localparam int unsigned CNT_W      = LEN_W + 1;
    localparam int unsigned CRD_W      = CNT_W + 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [LEN_W-1:0]      size_q, size_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      delivered_q, delivered_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        fifo_cnt_q, fifo_cnt_d;
    logic                  done_q, done_d;

    logic                  start_acc;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic                  last_issue;
    logic                  last_pop;
    logic [CNT_W-1:0]      size_ext;

    assign size_ext = {1'b0, size_q};

    // A word occupies a credit from its grant until the stream consumes it,
    // so the FIFO can always absorb every outstanding response.
    assign credit_ok = ({1'b0, inflight_q} + CRD_W'(fifo_cnt_q)) < CRD_W'(FIFO_DEPTH);

    assign start_acc  = req_start_i && ready_start_o;
    assign issue      = tcdm_req_o && tcdm_gnt_i;
    assign pop        = stream_valid_o && stream_ready_i;
    assign last_issue = issue && ((issued_q + CNT_W'(1)) == size_ext);
    assign last_pop   = pop && ((delivered_q + CNT_W'(1)) == size_ext);

    // Responses that arrive while idle can only belong to a transfer that was
    // abandoned by clear_i: a normal transfer reaches IDLE with nothing in
    // flight, and no new transfer starts until inflight drains to zero.
    assign push = tcdm_r_valid_i && !clear_i && (state_q != IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_acc && (trans_size_i != '0)) state_d = RUN;
                RUN:     if (last_issue) state_d = DRAIN;
                DRAIN:   if (last_pop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs, all derived from registered state
    always_comb begin
        ready_start_o  = (state_q == IDLE) && (inflight_q == '0);
        tcdm_req_o     = (state_q == RUN) && credit_ok && (issued_q < size_ext);
        tcdm_add_o     = base_q + (ADDR_W'(issued_q) << BYTE_SHIFT);
        tcdm_wen_o     = 1'b1;
        tcdm_be_o      = '1;
        stream_valid_o = (fifo_cnt_q != '0);
        stream_data_o  = mem_q[rd_ptr_q];
        done_o         = done_q;
    end

    // Transfer bookkeeping and response FIFO
    always_comb begin
        base_d      = base_q;
        size_d      = size_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = inflight_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        done_d      = 1'b0;

        // inflight keeps counting through a clear so that the responses of
        // the abandoned transfer can still be recognised and dropped.
        if (issue && !tcdm_r_valid_i) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && tcdm_r_valid_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        if (clear_i) begin
            issued_d    = '0;
            delivered_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end else begin
            if (start_acc) begin
                base_d      = base_addr_i;
                size_d      = trans_size_i;
                issued_d    = '0;
                delivered_d = '0;
                done_d      = (trans_size_i == '0);
            end
            if (issue) begin
                issued_d = issued_q + CNT_W'(1);
            end
            if (pop) begin
                delivered_d = delivered_q + CNT_W'(1);
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = tcdm_r_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                fifo_cnt_d = fifo_cnt_q - (PTR_W+1)'(1);
            end
            if ((state_q == DRAIN) && last_pop) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q      <= '0;
            size_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            base_q      <= base_d;
            size_q      <= size_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_mac_source_ctrl.sv
// Testbench for mac_source_ctrl. A behavioural TCDM slave (random grant,
// in-order responses with configurable latency, data derived from the
// address) and a stream sink surround the DUT. Each transfer is checked
// against the word sequence implied by its base address and size.

module tb_mac_source_ctrl;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        req_start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] trans_size_i = '0;
    logic        ready_start_o, done_o, tcdm_req_o, tcdm_wen_o, stream_valid_o;
    logic        tcdm_gnt_i = 1'b0;
    logic        tcdm_r_valid_i = 1'b0;
    logic        stream_ready_i = 1'b0;
    logic [31:0] tcdm_add_o, stream_data_o;
    logic [31:0] tcdm_r_data_i = '0;
    logic [3:0]  tcdm_be_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Environment knobs
    bit gnt_rand = 0, gnt_val = 1, ready_rand = 0, ready_val = 1;
    int gnt_limit = -1;
    int lat_min = 1, lat_max = 1;
    logic [31:0] salt = 32'h5A5A_1234;

    // Environment logs
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] g_addr[$];
    int          g_cyc[$];
    logic [31:0] h_data[$];
    int          h_cyc[$];
    int          d_cyc[$];
    bit          d_rdy[$];
    int          max_outst = 0;

    mac_source_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_start_i(req_start_i), .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
        .ready_start_o(ready_start_o), .done_o(done_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .stream_data_o(stream_data_o), .stream_valid_o(stream_valid_o),
        .stream_ready_i(stream_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // TCDM slave and stream sink: observe at negedge, drive just after posedge
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (tcdm_req_o && tcdm_gnt_i) begin
                    g_addr.push_back(tcdm_add_o);
                    g_cyc.push_back(cyc);
                    pend_addr.push_back(tcdm_add_o);
                    pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                end
                if (stream_valid_o && stream_ready_i) begin
                    h_data.push_back(stream_data_o);
                    h_cyc.push_back(cyc);
                end
                if (done_o) begin
                    d_cyc.push_back(cyc);
                    d_rdy.push_back(ready_start_o);
                end
                if (g_addr.size() - h_data.size() > max_outst)
                    max_outst = g_addr.size() - h_data.size();
            end
            @(posedge clk_i);
            #1;
            cyc++;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                tcdm_r_valid_i = 1'b1;
                tcdm_r_data_i  = rd_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                tcdm_r_valid_i = 1'b0;
                tcdm_r_data_i  = $urandom;
            end
            if (gnt_limit >= 0 && g_addr.size() >= gnt_limit) tcdm_gnt_i = 1'b0;
            else if (gnt_rand) tcdm_gnt_i = ($urandom_range(0, 99) < 70);
            else tcdm_gnt_i = gnt_val;
            if (ready_rand) stream_ready_i = ($urandom_range(0, 99) < 60);
            else stream_ready_i = ready_val;
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_logs();
        g_addr.delete(); g_cyc.delete(); h_data.delete(); h_cyc.delete();
        d_cyc.delete(); d_rdy.delete();
        max_outst = 0;
    endtask

    task automatic settle();
        step(); step();
        clear_logs();
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, output int s);
        req_start_i  = 1'b1;
        base_addr_i  = b;
        trans_size_i = n;
        s = cyc;
        step();
        req_start_i  = 1'b0;
        base_addr_i  = $urandom;
        trans_size_i = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (d_cyc.size() > 0) ok = 1;
        end
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        checks++; if (ready_start_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_start: got %b expected 1", ready_start_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (tcdm_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", tcdm_req_o); end
        checks++; if (tcdm_add_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_add: got %h expected 0", tcdm_add_o); end
        checks++; if (stream_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", stream_valid_o); end
        checks++; if (stream_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", stream_data_o); end
        checks++; if (tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF) begin errors++; $display("[TB] FAIL reset_wen_be: got %b/%h expected 1/f", tcdm_wen_o, tcdm_be_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        settle();
    endtask

    task automatic test_basic();
        int s; bit ok;
        gnt_rand = 0; gnt_val = 1; lat_min = 1; lat_max = 1; ready_rand = 0; ready_val = 1; gnt_limit = -1;
        settle();
        pulse_start(32'h1000, 16'd4, s);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done_timeout: got no done expected done"); end
        checks++; if (g_addr.size() != 4) begin errors++; $display("[TB] FAIL basic_grants: got %0d expected 4", g_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ea = 32'h1000 + 32'(4 * k);
            checks++; if (k >= g_addr.size() || g_addr[k] !== ea || g_cyc[k] != s + 1 + k) begin
                errors++; $display("[TB] FAIL basic_addr[%0d]: got %h @%0d expected %h @%0d", k, g_addr[k], g_cyc[k], ea, s + 1 + k); end
            checks++; if (k >= h_data.size() || h_data[k] !== rd_word(ea) || h_cyc[k] != s + 3 + k) begin
                errors++; $display("[TB] FAIL basic_data[%0d]: got %h @%0d expected %h @%0d", k, h_data[k], h_cyc[k], rd_word(ea), s + 3 + k); end
        end
        checks++; if (d_cyc.size() != 1 || d_cyc[0] != s + 7) begin
            errors++; $display("[TB] FAIL basic_done_cycle: got %0d pulses first @%0d expected 1 @%0d", d_cyc.size(), d_cyc[0], s + 7); end
        checks++; if (d_rdy.size() < 1 || d_rdy[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_ready_at_done: got %b expected 1", d_rdy[0]); end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        logic [31:0] b = 32'h0002_0000 + ($urandom & 32'h0000_FFFC);
        gnt_rand = 0; gnt_val = 1; lat_min = 1; lat_max = 1; ready_rand = 0; ready_val = 0; gnt_limit = -1;
        settle();
        pulse_start(b, 16'd10, s);
        for (int i = 0; i < 20; i++) begin
            step();
            if (stream_valid_o) begin
                checks++; if (stream_data_o !== rd_word(b)) begin
                    errors++; $display("[TB] FAIL bp_head_stable: got %h expected %h", stream_data_o, rd_word(b)); end
            end
        end
        checks++; if (g_addr.size() != DEPTH) begin errors++; $display("[TB] FAIL bp_grant_limit: got %0d expected %0d", g_addr.size(), DEPTH); end
        checks++; if (tcdm_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_low: got %b expected 0", tcdm_req_o); end
        checks++; if (stream_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", stream_valid_o); end
        ready_val = 1;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_timeout: got no done expected done"); end
        for (int k = 0; k < 10; k++) begin
            logic [31:0] ea = b + 32'(4 * k);
            checks++; if (k >= h_data.size() || h_data[k] !== rd_word(ea)) begin
                errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, h_data[k], rd_word(ea)); end
        end
        checks++; if (g_addr.size() != 10 || h_data.size() != 10 || d_cyc.size() != 1) begin
            errors++; $display("[TB] FAIL bp_counts: got %0d/%0d/%0d expected 10/10/1", g_addr.size(), h_data.size(), d_cyc.size()); end
        checks++; if (max_outst > DEPTH) begin errors++; $display("[TB] FAIL bp_credit: got %0d expected <= %0d", max_outst, DEPTH); end
    endtask

    task automatic test_gnt_stall();
        int s; bit ok;
        logic [31:0] b = 32'h0003_0000 + ($urandom & 32'h0000_FFFC);
        gnt_rand = 0; gnt_val = 0; lat_min = 1; lat_max = 2; ready_rand = 0; ready_val = 1; gnt_limit = -1;
        settle();
        pulse_start(b, 16'd3, s);
        for (int i = 0; i < 5; i++) begin
            checks++; if (tcdm_req_o !== 1'b1 || tcdm_add_o !== b || stream_valid_o !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_hold[%0d]: got req=%b add=%h valid=%b expected 1 %h 0", i, tcdm_req_o, tcdm_add_o, stream_valid_o, b); end
            step();
        end
        gnt_val = 1;
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_done_timeout: got no done expected done"); end
        checks++; if (g_cyc.size() < 1 || g_cyc[0] <= s + 5) begin errors++; $display("[TB] FAIL stall_first_grant: got @%0d expected after %0d", g_cyc[0], s + 5); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ea = b + 32'(4 * k);
            checks++; if (k >= g_addr.size() || g_addr[k] !== ea || k >= h_data.size() || h_data[k] !== rd_word(ea)) begin
                errors++; $display("[TB] FAIL stall_word[%0d]: got %h/%h expected %h/%h", k, g_addr[k], h_data[k], ea, rd_word(ea)); end
        end
        checks++; if (d_cyc.size() != 1 || h_cyc.size() != 3 || d_cyc[0] != h_cyc[2] + 1) begin
            errors++; $display("[TB] FAIL stall_done: got %0d pulses @%0d expected 1 @%0d", d_cyc.size(), d_cyc[0], h_cyc[2] + 1); end
    endtask

    task automatic test_zero_size();
        int s;
        gnt_rand = 0; gnt_val = 1; lat_min = 1; lat_max = 1; ready_rand = 0; ready_val = 1; gnt_limit = -1;
        settle();
        checks++; if (ready_start_o !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready_before: got %b expected 1", ready_start_o); end
        pulse_start(32'h0000_4000, 16'd0, s);
        checks++; if (done_o !== 1'b1 || ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_done_pulse: got done=%b rdy=%b req=%b expected 1 1 0", done_o, ready_start_o, tcdm_req_o); end
        step();
        checks++; if (done_o !== 1'b0 || ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_after: got done=%b rdy=%b req=%b expected 0 1 0", done_o, ready_start_o, tcdm_req_o); end
        step(); step();
        checks++; if (g_addr.size() != 0 || d_cyc.size() != 1 || d_cyc[0] != s + 1) begin
            errors++; $display("[TB] FAIL zero_summary: got grants=%0d dones=%0d @%0d expected 0 1 @%0d", g_addr.size(), d_cyc.size(), d_cyc[0], s + 1); end
    endtask

    task automatic test_ignored_start();
        int s, s2; bit ok;
        logic [31:0] b = 32'h0005_0000 + ($urandom & 32'h0000_FFFC);
        gnt_rand = 1; lat_min = 1; lat_max = 3; ready_rand = 1; gnt_limit = -1;
        settle();
        pulse_start(b, 16'd6, s);
        step(); step();
        checks++; if (ready_start_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_ready_busy: got %b expected 0", ready_start_o); end
        pulse_start(b + 32'h0100_0000, 16'd9, s2);
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ign_done_timeout: got no done expected done"); end
        checks++; if (g_addr.size() != 6 || h_data.size() != 6 || d_cyc.size() != 1) begin
            errors++; $display("[TB] FAIL ign_counts: got %0d/%0d/%0d expected 6/6/1", g_addr.size(), h_data.size(), d_cyc.size()); end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ea = b + 32'(4 * k);
            checks++; if (k >= g_addr.size() || g_addr[k] !== ea || k >= h_data.size() || h_data[k] !== rd_word(ea)) begin
                errors++; $display("[TB] FAIL ign_word[%0d]: got %h/%h expected %h/%h", k, g_addr[k], h_data[k], ea, rd_word(ea)); end
        end
    endtask

    task automatic test_clear();
        int s, rdy_cyc; bit ok;
        logic [31:0] b = 32'h0006_0000 + ($urandom & 32'h0000_FFFC);
        gnt_rand = 0; gnt_val = 1; lat_min = 3; lat_max = 3; ready_rand = 0; ready_val = 1; gnt_limit = 2;
        settle();
        pulse_start(b, 16'd8, s);
        for (int i = 0; i < 20 && g_addr.size() < 2; i++) step();
        checks++; if (g_addr.size() != 2) begin errors++; $display("[TB] FAIL clr_two_grants: got %0d expected 2", g_addr.size()); end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++; if (tcdm_req_o !== 1'b0 || ready_start_o !== 1'b0 || stream_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_next: got req=%b rdy=%b valid=%b expected 0 0 0", tcdm_req_o, ready_start_o, stream_valid_o); end
        rdy_cyc = -1;
        for (int i = 0; i < 30 && rdy_cyc < 0; i++) begin
            if (ready_start_o) rdy_cyc = cyc;
            else begin
                checks++; if (stream_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_discard: got valid=%b expected 0", stream_valid_o); end
                step();
            end
        end
        checks++; if (g_cyc.size() < 2 || rdy_cyc != g_cyc[1] + 3 + 1) begin
            errors++; $display("[TB] FAIL clr_ready_return: got @%0d expected @%0d", rdy_cyc, g_cyc[1] + 4); end
        checks++; if (h_data.size() != 0 || d_cyc.size() != 0) begin
            errors++; $display("[TB] FAIL clr_no_output: got %0d words %0d dones expected 0 0", h_data.size(), d_cyc.size()); end
        gnt_limit = -1; gnt_rand = 1; lat_min = 1; lat_max = 2; ready_rand = 1;
        b = 32'h0007_0000 + ($urandom & 32'h0000_FFFC);
        settle();
        pulse_start(b, 16'd5, s);
        wait_done(300, ok);
        checks++; if (!ok || g_addr.size() != 5 || h_data.size() != 5 || d_cyc.size() != 1) begin
            errors++; $display("[TB] FAIL clr_rerun_counts: got %0d/%0d/%0d expected 5/5/1", g_addr.size(), h_data.size(), d_cyc.size()); end
        for (int k = 0; k < 5; k++) begin
            logic [31:0] ea = b + 32'(4 * k);
            checks++; if (k >= h_data.size() || h_data[k] !== rd_word(ea)) begin
                errors++; $display("[TB] FAIL clr_rerun_data[%0d]: got %h expected %h", k, h_data[k], rd_word(ea)); end
        end
    endtask

    task automatic test_back_to_back();
        int s, n; bit ok;
        logic [31:0] b;
        gnt_rand = 1; lat_min = 1; lat_max = 4; ready_rand = 1; gnt_limit = -1;
        settle();
        for (int t = 0; t < 8; t++) begin
            b = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            n = $urandom_range(1, 12);
            salt = $urandom;
            for (int i = 0; i < 50 && !ready_start_o; i++) step();
            clear_logs();
            pulse_start(b, 16'(n), s);
            wait_done(1000, ok);
            checks++; if (!ok || g_addr.size() != n || h_data.size() != n || d_cyc.size() != 1) begin
                errors++; $display("[TB] FAIL rnd%0d_counts: got %0d/%0d/%0d expected %0d/%0d/1", t, g_addr.size(), h_data.size(), d_cyc.size(), n, n); end
            for (int k = 0; k < n; k++) begin
                logic [31:0] ea = b + 32'(4 * k);
                checks++; if (k >= g_addr.size() || g_addr[k] !== ea || k >= h_data.size() || h_data[k] !== rd_word(ea)) begin
                    errors++; $display("[TB] FAIL rnd%0d_word[%0d]: got %h/%h expected %h/%h", t, k, g_addr[k], h_data[k], ea, rd_word(ea)); end
            end
            checks++; if (h_cyc.size() != n || d_cyc.size() < 1 || d_cyc[0] != h_cyc[n-1] + 1 || d_rdy[0] !== 1'b1) begin
                errors++; $display("[TB] FAIL rnd%0d_done: got @%0d rdy=%b expected @%0d rdy=1", t, d_cyc[0], d_rdy[0], h_cyc[n-1] + 1); end
            checks++; if (max_outst > DEPTH) begin errors++; $display("[TB] FAIL rnd%0d_credit: got %0d expected <= %0d", t, max_outst, DEPTH); end
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        gnt_rand = 0; gnt_val = 1; lat_min = 2; lat_max = 2; ready_rand = 0; ready_val = 0; gnt_limit = -1;
        settle();
        pulse_start(32'h0009_0000, 16'd8, s);
        step(); step(); step();
        rst_ni = 1'b0;
        #1;
        checks++; if (tcdm_req_o !== 1'b0 || ready_start_o !== 1'b1 || stream_valid_o !== 1'b0 || done_o !== 1'b0 || tcdm_add_o !== 32'h0) begin
            errors++; $display("[TB] FAIL rstmid_outputs: got req=%b rdy=%b valid=%b done=%b add=%h expected 0 1 0 0 0", tcdm_req_o, ready_start_o, stream_valid_o, done_o, tcdm_add_o); end
        pend_addr.delete(); pend_due.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        ready_val = 1;
        settle();
        checks++; if (ready_start_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", ready_start_o); end
        pulse_start(32'h000A_0000, 16'd2, s);
        wait_done(100, ok);
        checks++; if (!ok || h_data.size() != 2 || h_data[0] !== rd_word(32'h000A_0000) || h_data[1] !== rd_word(32'h000A_0004)) begin
            errors++; $display("[TB] FAIL rstmid_rerun: got %0d words first %h expected 2 first %h", h_data.size(), h_data[0], rd_word(32'h000A_0000)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gnt_stall();
        test_zero_size();
        test_ignored_start();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_source_ctrl.md
Name: mac_source_ctrl

Overview:
- Responder end of the streamer start handshake used by the MAC control FSM.
- Accepts a `req_start` pulse carrying a base address and a word count, and reports `ready_start` when idle.
- Issues TCDM read requests, buffers the returned words in a small FIFO and presents them as a valid/ready data stream to the MAC engine.
- Pulses `done` once the last word has been consumed downstream. One instance per source stream (a, b, c).

Parameters:
- ADDR_W, 32, TCDM address width.
- DATA_W, 32, TCDM/stream word width; address stride per word is DATA_W/8.
- LEN_W, 16, width of the transfer-size field.
- FIFO_DEPTH, 4, response buffer depth; also the maximum number of words in flight (requested but not yet consumed). Power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- req_start_i  in  1  start request, single-cycle pulse
- base_addr_i  in  ADDR_W  first word byte address, sampled on accepted req_start_i
- trans_size_i  in  LEN_W  number of words, sampled on accepted req_start_i
- ready_start_o  out  1  block can accept req_start_i
- done_o  out  1  one-cycle pulse, transfer complete
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  ADDR_W  TCDM byte address
- tcdm_wen_o  out  1  constant 1 (read)
- tcdm_be_o  out  DATA_W/8  constant all-ones
- tcdm_r_data_i  in  DATA_W  read data
- tcdm_r_valid_i  in  1  read data valid
- stream_data_o  out  DATA_W  stream payload (FIFO head)
- stream_valid_o  out  1  stream valid
- stream_ready_i  in  1  stream ready

Behaviour:
- Reset values:
  - Outputs: `ready_start_o`=1, `done_o`=0, `tcdm_req_o`=0, `tcdm_add_o`=0, `stream_valid_o`=0, `stream_data_o`=0.
  - Internal state: IDLE; all counters and FIFO pointers 0.
- States: IDLE, RUN, DRAIN.
- Counters (LEN_W+1 bits, no wrap):
  - `issued`: granted requests.
  - `delivered`: stream handshakes.
  - `inflight`: granted requests whose response has not yet returned.
- Free-credit rule: a request may be issued only if inflight + fifo_count < FIFO_DEPTH. The FIFO therefore never overflows.
- `ready_start_o` = (state==IDLE) && (inflight==0).
- IDLE:
  - req_start_i && ready_start_o: latch base/size, zero `issued` and `delivered`.
  - If size==0: pulse `done_o` next cycle and stay IDLE.
  - Otherwise go to RUN.
  - req_start_i while ready_start_o=0 is ignored; the same applies in every state.
- RUN:
  - `tcdm_req_o` = credit available && issued < size.
  - `tcdm_add_o` = base + issued*(DATA_W/8), computed mod 2^ADDR_W.
  - `tcdm_req_o` and `tcdm_add_o` are combinational from registered state.
  - On req&&gnt: issued++, inflight++.
  - Request held with stable address until granted.
  - When issued reaches size (including the granting cycle): go to DRAIN.
- DRAIN:
  - No requests.
  - When delivered==size: `done_o`=1 for exactly one cycle (registered, cycle after last stream handshake); go to IDLE.
- Responses:
  - Each `tcdm_r_valid_i` pushes `tcdm_r_data_i` into the FIFO and decrements `inflight`.
  - Grant and response in the same cycle: `inflight` unchanged.
  - Responses arrive in request order; latency ≥1 cycle after grant, unbounded.
- Stream side:
  - `stream_valid_o` = FIFO not empty.
  - `stream_data_o` = FIFO head, stable while valid && !ready.
  - Pop on valid&&ready; delivered++.
  - Push and pop in the same cycle on a full FIFO is legal (count unchanged).
  - Push to an empty FIFO is visible on the stream the next cycle, i.e. 1 cycle of buffering latency.
- Throughput: with `gnt` always high, `r_valid` 1 cycle after grant and `ready` always high: one word per cycle; first stream valid 2 cycles after the request.
- clear_i (any state, priority over everything except reset):
  - Next cycle: state IDLE, FIFO empty, `issued`/`delivered` = 0, `done_o`=0, `tcdm_req_o`=0.
  - `inflight` is NOT cleared; responses still returning are discarded (decrement `inflight`, no push).
  - `ready_start_o` stays 0 until `inflight`==0.
- Reset mid-operation: immediate return to reset values, including `inflight`=0.

Test Plan:
- Base 0x1000, size 4, gnt=1, r_valid 1-cycle latency, ready=1 -> addresses 0x1000/0x1004/0x1008/0x100C on consecutive cycles; data out in order 4 consecutive cycles; `done_o` single pulse 1 cycle after last handshake; `ready_start_o`=1 again that cycle.
- Size 10, stream_ready_i=0 for 20 cycles, then 1 -> exactly 4 grants then `tcdm_req_o`=0; FIFO head stable; after release all 10 words delivered in order, one `done_o`.
- Size 3, gnt low 5 cycles on first request -> `tcdm_add_o` held at base; no stream output until grant; completes correctly.
- Size 0 -> no TCDM request; `done_o` pulse the cycle after req_start; `ready_start_o` stays 1.
- req_start_i pulsed during RUN with a different base -> ignored; original transfer addresses and count unaffected.
- Size 8, clear_i after 2 grants with 2 responses outstanding (latency 3) -> next cycle IDLE, `req_o`=0, `ready_start_o`=0 until both responses return (discarded, no `stream_valid_o`), then `ready_start_o`=1; a new transfer runs normally.
